// File: rtl/rv_trace_serializer.sv
// Retirement-trace record FIFO plus a framed little-endian byte serializer on a valid/ready link.
// Optional macro TRACE_CHECKSUM_EN appends an XOR checksum byte (flags through last field) to each frame.
`timescale 1ns/1ps

module rv_trace_serializer #(
    parameter int FIFO_DEPTH = 8,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  retire_valid_i,
    input  logic [31:0]           pc_i,
    input  logic [31:0]           instr_i,
    input  logic [4:0]            reg_addr_i,
    input  logic [31:0]           reg_data_i,
    input  logic [31:0]           mem_addr_i,
    input  logic [31:0]           mem_data_i,
    input  logic                  mem_wrt_i,
    output logic                  tx_valid_o,
    output logic [7:0]            tx_data_o,
    input  logic                  tx_ready_i,
    output logic                  busy_o,
    output logic                  overflow_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o,
    output logic [3:0]            dbg_state_o
);

    // Handshake: a byte moves on a rising edge where tx_valid_o && tx_ready_i.
    // tx_valid_o/tx_data_o are registers; once valid is raised the byte is held
    // unchanged until accepted, and valid never looks at tx_ready_i combinationally.

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [7:0]    HDR_BYTE = 8'hA5;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic [31:0] maddr;
        logic [31:0] mdata;
        logic        mwrt;
    } rec_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_FLAGS,
        S_PC,
        S_INSTR,
        S_RD,
        S_RDATA,
        S_MADDR,
        S_MDATA
`ifdef TRACE_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    function automatic logic [7:0] byte_sel(input logic [31:0] v, input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = v[7:0];
            2'd1:    b = v[15:8];
            2'd2:    b = v[23:16];
            default: b = v[31:24];
        endcase
        return b;
    endfunction

    rec_t            r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    state_t          r_state;
    logic [1:0]      r_idx;
    rec_t            r_frame;
    logic            r_tx_valid;
    logic [7:0]      r_tx_data;

    rec_t            w_rec_in;
    rec_t            w_head;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_accept;

    state_t          w_nxt_state;
    logic [1:0]      w_nxt_idx;
    logic [7:0]      w_nxt_data;
    logic            w_last;
    logic            w_rw;
    logic            w_in_field;
    logic [1:0]      w_idx_inc;
    logic [31:0]     w_field;

    assign w_rec_in = '{pc: pc_i, instr: instr_i, rd: reg_addr_i, rdata: reg_data_i,
                        maddr: mem_addr_i, mdata: mem_data_i, mwrt: mem_wrt_i};
    assign w_head   = r_mem[r_rd_ptr];
    assign w_full   = (r_count == DEPTH_C);
    // Full is judged on the registered count, so a pop in the same cycle does not rescue a push.
    assign w_push   = retire_valid_i && !w_full;
    assign w_accept = r_tx_valid && tx_ready_i;
    assign w_pop    = (r_count != '0) &&
                      ((r_state == S_IDLE) || (w_accept && w_last));

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_rec_in;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (retire_valid_i && w_full) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != {DROP_CNT_W{1'b1}}) begin
                    r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
                end
            end
        end
    end

`ifdef TRACE_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_csum <= 8'h00;
        end else if (w_pop) begin
            r_csum <= 8'h00;
        end else if (w_accept && (r_state != S_HDR)) begin
            r_csum <= r_csum ^ r_tx_data;
        end
    end
`endif

    // Decode of the byte that follows the one currently on the link.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_data  = r_tx_data;
        w_last      = 1'b0;
        w_rw        = (r_frame.rd != 5'd0);
        w_idx_inc   = r_idx + 2'd1;
        w_field     = r_frame.pc;
        w_in_field  = 1'b0;
        case (r_state)
            S_PC:    w_field = r_frame.pc;
            S_INSTR: w_field = r_frame.instr;
            S_RDATA: w_field = r_frame.rdata;
            S_MADDR: w_field = r_frame.maddr;
            S_MDATA: w_field = r_frame.mdata;
            default: w_field = r_frame.pc;
        endcase
        if ((r_state == S_PC) || (r_state == S_INSTR) || (r_state == S_RDATA) ||
            (r_state == S_MADDR) || (r_state == S_MDATA)) begin
            w_in_field = (r_idx != 2'd3);
        end

        if (w_in_field) begin
            w_nxt_idx  = w_idx_inc;
            w_nxt_data = byte_sel(w_field, w_idx_inc);
        end else begin
            w_nxt_idx = 2'd0;
            case (r_state)
                S_HDR: begin
                    w_nxt_state = S_FLAGS;
                    w_nxt_data  = {6'b0, r_frame.mwrt, w_rw};
                end
                S_FLAGS: begin
                    w_nxt_state = S_PC;
                    w_nxt_data  = r_frame.pc[7:0];
                end
                S_PC: begin
                    w_nxt_state = S_INSTR;
                    w_nxt_data  = r_frame.instr[7:0];
                end
                S_INSTR: begin
                    if (w_rw) begin
                        w_nxt_state = S_RD;
                        w_nxt_data  = {3'b0, r_frame.rd};
                    end else if (r_frame.mwrt) begin
                        w_nxt_state = S_MADDR;
                        w_nxt_data  = r_frame.maddr[7:0];
                    end else begin
                        w_last = 1'b1;
                    end
                end
                S_RD: begin
                    w_nxt_state = S_RDATA;
                    w_nxt_data  = r_frame.rdata[7:0];
                end
                S_RDATA: begin
                    if (r_frame.mwrt) begin
                        w_nxt_state = S_MADDR;
                        w_nxt_data  = r_frame.maddr[7:0];
                    end else begin
                        w_last = 1'b1;
                    end
                end
                S_MADDR: begin
                    w_nxt_state = S_MDATA;
                    w_nxt_data  = r_frame.mdata[7:0];
                end
                S_MDATA: w_last = 1'b1;
`ifdef TRACE_CHECKSUM_EN
                S_CSUM:  w_last = 1'b1;
`endif
                default: ;
            endcase
        end

`ifdef TRACE_CHECKSUM_EN
        // The byte being accepted now is folded into the checksum on the fly.
        if (w_last && (r_state != S_CSUM)) begin
            w_last      = 1'b0;
            w_nxt_state = S_CSUM;
            w_nxt_data  = r_csum ^ r_tx_data;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= S_IDLE;
            r_idx      <= 2'd0;
            r_frame    <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_frame <= w_head;
                        r_state <= S_HDR;
                        r_idx   <= 2'd0;
                    end
                end
                default: begin
                    if (!r_tx_valid) begin
                        // First cycle in HDR after leaving IDLE: present the header.
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= HDR_BYTE;
                    end else if (w_accept) begin
                        if (w_last) begin
                            if (w_pop) begin
                                r_frame   <= w_head;
                                r_state   <= S_HDR;
                                r_idx     <= 2'd0;
                                r_tx_data <= HDR_BYTE;
                            end else begin
                                r_state    <= S_IDLE;
                                r_idx      <= 2'd0;
                                r_tx_valid <= 1'b0;
                            end
                        end else begin
                            r_state   <= w_nxt_state;
                            r_idx     <= w_nxt_idx;
                            r_tx_data <= w_nxt_data;
                        end
                    end
                end
            endcase
        end
    end

    assign tx_valid_o  = r_tx_valid;
    assign tx_data_o   = r_tx_data;
    assign busy_o      = (r_count != '0) || (r_state != S_IDLE);
    assign overflow_o  = r_overflow;
    assign drop_cnt_o  = r_drop_cnt;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_rv_trace_serializer.sv
// Bench for rv_trace_serializer: directed latency/backpressure/overflow/reset scenarios
// plus a randomized phase, all checked by a byte scoreboard fed from a frame-level model.
`timescale 1ns/1ps

module tb_rv_trace_serializer;

  localparam int FIFO_DEPTH = 8;
  localparam int DROP_CNT_W = 16;
`ifdef TRACE_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic                  clk_i = 1'b0;
  logic                  rstn_i = 1'b0;
  logic                  retire_valid_i = 1'b0;
  logic [31:0]           pc_i = '0;
  logic [31:0]           instr_i = '0;
  logic [4:0]            reg_addr_i = '0;
  logic [31:0]           reg_data_i = '0;
  logic [31:0]           mem_addr_i = '0;
  logic [31:0]           mem_data_i = '0;
  logic                  mem_wrt_i = 1'b0;
  logic                  tx_valid_o;
  logic [7:0]            tx_data_o;
  logic                  tx_ready_i = 1'b0;
  logic                  busy_o;
  logic                  overflow_o;
  logic [DROP_CNT_W-1:0] drop_cnt_o;
  logic [3:0]            dbg_state_o;

  rv_trace_serializer #(.FIFO_DEPTH(FIFO_DEPTH), .DROP_CNT_W(DROP_CNT_W)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .retire_valid_i(retire_valid_i),
    .pc_i(pc_i), .instr_i(instr_i), .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_wrt_i(mem_wrt_i),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .busy_o(busy_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int         len_q[$];
  int         cur_bytes = 0;
  int         frames_done = 0;
  int         last_frame_len = 0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: the frame for one record, built straight from the frame rules.
  function automatic void model_push(input logic [31:0] pc, input logic [31:0] instr,
                                     input logic [4:0] rd, input logic [31:0] rdata,
                                     input logic [31:0] maddr, input logic [31:0] mdata,
                                     input logic mwrt);
    logic [7:0] b[$];
    logic [7:0] x;
    b.push_back(8'hA5);
    b.push_back(8'((mwrt ? 2 : 0) + (rd != 0 ? 1 : 0)));
    for (int i = 0; i < 4; i++) b.push_back(8'(pc >> (8 * i)));
    for (int i = 0; i < 4; i++) b.push_back(8'(instr >> (8 * i)));
    if (rd != 0) begin
      b.push_back(8'(rd));
      for (int i = 0; i < 4; i++) b.push_back(8'(rdata >> (8 * i)));
    end
    if (mwrt) begin
      for (int i = 0; i < 4; i++) b.push_back(8'(maddr >> (8 * i)));
      for (int i = 0; i < 4; i++) b.push_back(8'(mdata >> (8 * i)));
    end
    if (CS != 0) begin
      x = 8'h00;
      for (int i = 1; i < b.size(); i++) x = x ^ b[i];
      b.push_back(x);
    end
    foreach (b[i]) exp_q.push_back(b[i]);
    len_q.push_back(b.size());
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    if (rstn_i && tx_valid_o && tx_ready_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got %0h want none", tx_data_o);
      end else begin
        check("stream_byte", tx_data_o, exp_q.pop_front());
        cur_bytes++;
        if (len_q.size() > 0 && cur_bytes == len_q[0]) begin
          void'(len_q.pop_front());
          last_frame_len = cur_bytes;
          cur_bytes = 0;
          frames_done++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_rec(input logic [31:0] pc, input logic [31:0] instr,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input logic [31:0] maddr, input logic [31:0] mdata,
                           input logic mwrt, input bit expect_kept);
    pc_i = pc; instr_i = instr; reg_addr_i = rd; reg_data_i = rdata;
    mem_addr_i = maddr; mem_data_i = mdata; mem_wrt_i = mwrt;
    retire_valid_i = 1'b1;
    if (expect_kept) model_push(pc, instr, rd, rdata, maddr, mdata, mwrt);
    @(posedge clk_i); #1;
    retire_valid_i = 1'b0;
  endtask

  task automatic drive_rand(input bit expect_kept);
    logic [4:0] rd;
    rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    drive_rec($urandom, $urandom, rd, $urandom, $urandom, $urandom,
              1'($urandom_range(0, 1)), expect_kept);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic drain(input string name);
    int i;
    tx_ready_i = 1'b1;
    i = 0;
    while ((exp_q.size() != 0 || busy_o) && i < 2000) begin
      @(posedge clk_i); #1;
      i++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_idle"}, busy_o, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] t1[15] = '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00,
                         8'h50, 8'h00, 8'h01, 8'h05, 8'h00, 8'h00, 8'h00};
  int         wait_i;
  int         base_frames;
  logic [7:0] held;

  initial begin
    // Reset state.
    #1;
    check("rst_tx_valid", tx_valid_o, 1'b0);
    check("rst_tx_data", tx_data_o, 8'h00);
    check("rst_busy", busy_o, 1'b0);
    check("rst_overflow", overflow_o, 1'b0);
    check("rst_drop_cnt", drop_cnt_o, 0);
    check("rst_state_idle", dbg_state_o, 0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i); #1;

    // Single register-write record: literal frame and capture-to-header latency.
    tx_ready_i = 1'b1;
    foreach (t1[i]) exp_q.push_back(t1[i]);
    if (CS != 0) exp_q.push_back(8'hD6);
    len_q.push_back(15 + CS);
    drive_rec(32'h10, 32'h00500093, 5'd1, 32'd5, 32'h0, 32'h0, 1'b0, 1'b0);
    check("lat_capture_edge", tx_valid_o, 1'b0);
    @(posedge clk_i); #1;
    check("lat_pop_edge", tx_valid_o, 1'b0);
    @(posedge clk_i); #1;
    check("lat_hdr_valid", tx_valid_o, 1'b1);
    check("lat_hdr_data", tx_data_o, 8'hA5);
    drain("t1");
    check("t1_frame_len", last_frame_len, 15 + CS);

    // Store-only record.
    drive_rec(32'h100, 32'h00112023, 5'd0, 32'h12345678, 32'h4, 32'hDEADBEEF, 1'b1, 1'b1);
    drain("t2");
    check("t2_frame_len", last_frame_len, 18 + CS);

    // Backpressure mid-PC field.
    drive_rec(32'hCAFEF00D, 32'h00A00113, 5'd2, 32'h0BADC0DE, 32'h80, 32'h55AA55AA, 1'b1, 1'b1);
    wait_i = 0;
    while (cur_bytes < 3 && wait_i < 50) begin
      @(posedge clk_i); #1;
      wait_i++;
    end
    check("bp_reached_pc", wait_i < 50, 1'b1);
    tx_ready_i = 1'b0;
    held = tx_data_o;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      check("bp_valid_held", tx_valid_o, 1'b1);
      check("bp_data_held", tx_data_o, held);
    end
    drain("bp");
    check("bp_frame_len", last_frame_len, 23 + CS);

    // Randomized traffic with random sink stalls, kept below FIFO capacity.
    for (int c = 0; c < 600; c++) begin
      tx_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1 && len_q.size() < FIFO_DEPTH) drive_rand(1'b1);
      else idle_cycles(1);
    end
    drain("rand");
    check("rand_no_drop", drop_cnt_o, 0);
    check("rand_no_overflow", overflow_o, 1'b0);

    // Overflow: one frame stalled on the link, then 12 back-to-back records.
    tx_ready_i = 1'b0;
    base_frames = frames_done;
    drive_rand(1'b1);
    wait_i = 0;
    while (!tx_valid_o && wait_i < 20) begin
      @(posedge clk_i); #1;
      wait_i++;
    end
    check("ovf_stall_valid", tx_valid_o, 1'b1);
    for (int i = 0; i < 12; i++) drive_rand(i < FIFO_DEPTH);
    check("ovf_drop_cnt", drop_cnt_o, 4);
    check("ovf_flag", overflow_o, 1'b1);
    check("ovf_busy", busy_o, 1'b1);
    drain("ovf");
    check("ovf_frames", frames_done - base_frames, FIFO_DEPTH + 1);
    check("ovf_sticky", overflow_o, 1'b1);

    // Asynchronous reset in the middle of a frame.
    tx_ready_i = 1'b1;
    drive_rand(1'b1);
    wait_i = 0;
    while (cur_bytes < 4 && wait_i < 50) begin
      @(posedge clk_i); #1;
      wait_i++;
    end
    check("mid_reached", wait_i < 50, 1'b1);
    #2;
    rstn_i = 1'b0;
    #1;
    check("mid_rst_valid", tx_valid_o, 1'b0);
    check("mid_rst_drop", drop_cnt_o, 0);
    check("mid_rst_overflow", overflow_o, 1'b0);
    check("mid_rst_busy", busy_o, 1'b0);
    exp_q.delete();
    len_q.delete();
    cur_bytes = 0;
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    @(posedge clk_i); #1;
    base_frames = frames_done;
    drive_rand(1'b1);
    drain("post_rst");
    check("post_rst_frames", frames_done - base_frames, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
